aixh_mxc_upper_ptile_cell_pex: RTL and testbench

AIXH_MXC_UPPER_PTILE_CELL_PEX -- requirements
Module: aixh_mxc_upper_ptile_cell_pex

---
 rtl/aixh_mxc_upper_ptile_cell_pex_pkg.sv | 35 +++
 rtl/aixh_mxc_pex_lane.sv | 47 ++++
 rtl/aixh_mxc_upper_ptile_cell_pex.sv | 143 ++++++++++++++
 tb/tb_aixh_mxc_upper_ptile_cell_pex.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aixh_mxc_upper_ptile_cell_pex_pkg.sv
// Shared types and helpers for the MXC processing-element cell.
// Holds the operand modes, the shift weights and the radix-4 Booth partial-product selector.
package aixh_mxc_pkg;

    typedef enum logic [1:0] {
        ModeInt4   = 2'b00,
        ModeInt8Ss = 2'b01,
        ModeInt8Us = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ShiftX1    = 2'b00,
        ShiftX2p8  = 2'b01,
        ShiftX2p16 = 2'b10
    } shift_e;

    localparam int unsigned LaneProdW = 17;

    // Radix-4 Booth digit: trip = {b[2k+1], b[2k], b[2k-1]} selects 0, +-m or +-2m.
    function automatic logic signed [LaneProdW-1:0] booth_pp(
        input logic [2:0]                  trip,
        input logic signed [LaneProdW-1:0] m
    );
        logic signed [LaneProdW-1:0] pp;
        case (trip)
            3'b001, 3'b010: pp = m;
            3'b011:         pp = m <<< 1;
            3'b100:         pp = -(m <<< 1);
            3'b101, 3'b110: pp = -m;
            default:        pp = '0;
        endcase
        return pp;
    endfunction

endpackage

// File: rtl/aixh_mxc_pex_lane.sv
// One multiplier lane: 8x8 (signed or unsigned-by-signed) or dual 4x4 signed dot,
// all computed with radix-4 Booth recoding of the v operand.
module aixh_mxc_pex_lane
    import aixh_mxc_pkg::*;
(
    input  logic [1:0]                  mode_i,
    input  logic [7:0]                  u_i,
    input  logic [7:0]                  v_i,
    output logic signed [LaneProdW-1:0] prod_o
);

    logic signed [LaneProdW-1:0] m8;
    logic signed [LaneProdW-1:0] m4_lo;
    logic signed [LaneProdW-1:0] m4_hi;
    logic [8:0]                  v8x;
    logic [4:0]                  v4x_lo;
    logic [4:0]                  v4x_hi;
    logic signed [LaneProdW-1:0] p8;
    logic signed [LaneProdW-1:0] p4;

    always_comb begin
        // Mode 11 falls through to the signed-by-signed path.
        if (mode_i == ModeInt8Us) begin
            m8 = $signed({9'b0, u_i});
        end else begin
            m8 = $signed({{9{u_i[7]}}, u_i});
        end
        m4_lo  = $signed({{13{u_i[3]}}, u_i[3:0]});
        m4_hi  = $signed({{13{u_i[7]}}, u_i[7:4]});
        v8x    = {v_i, 1'b0};
        v4x_lo = {v_i[3:0], 1'b0};
        v4x_hi = {v_i[7:4], 1'b0};

        p8 = '0;
        for (int k = 0; k < 4; k++) begin
            p8 = p8 + (booth_pp(v8x[2*k +: 3], m8) <<< (2*k));
        end

        p4 = booth_pp(v4x_lo[2:0], m4_lo)
           + (booth_pp(v4x_lo[4:2], m4_lo) <<< 2)
           + booth_pp(v4x_hi[2:0], m4_hi)
           + (booth_pp(v4x_hi[4:2], m4_hi) <<< 2);

        prod_o = (mode_i == ModeInt4) ? p4 : p8;
    end

endmodule

// File: rtl/aixh_mxc_upper_ptile_cell_pex.sv
// Multi-lane multiply-accumulate cell: lane products summed, weighted, pipelined
// MSTAGES deep, then accumulated with optional saturation and a sticky overflow flag.
module aixh_mxc_upper_ptile_cell_pex
    import aixh_mxc_pkg::*;
#(
    parameter int unsigned LANES    = 2,
    parameter int unsigned MSTAGES  = 2,
    parameter int unsigned ACC_BITS = 48,
    parameter bit          SAT      = 1'b0
) (
    input  logic                       aixh_core_clk2x,
    input  logic                       aixh_core_rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_mode,
    input  logic [1:0]                 in_shift,
    input  logic                       in_afresh,
    input  logic                       in_last,
    input  logic [LANES*8-1:0]         in_udata,
    input  logic [LANES*8-1:0]         in_vdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [ACC_BITS-1:0] out_data,
    output logic                       out_ovf
);

    localparam int unsigned ProdW = LaneProdW + $clog2(LANES);
    localparam int unsigned WpW   = ProdW + 16;
    localparam int unsigned SumW  = ((ACC_BITS > WpW) ? ACC_BITS : WpW) + 1;

    logic signed [LaneProdW-1:0] lane_prod [LANES];
    logic signed [ProdW-1:0]     beat_prod;
    logic signed [WpW-1:0]       beat_wp;

    logic [MSTAGES-1:0]    st_valid_q;
    logic [MSTAGES-1:0]    st_afresh_q;
    logic [MSTAGES-1:0]    st_last_q;
    logic signed [WpW-1:0] st_wp_q [MSTAGES];

    logic signed [ACC_BITS-1:0] acc_q;
    logic                       ovf_q;
    logic                       out_valid_q;
    logic signed [ACC_BITS-1:0] out_data_q;
    logic                       out_ovf_q;

    logic                       advance;
    logic signed [SumW-1:0]     acc_base;
    logic signed [SumW-1:0]     acc_sum;
    logic [SumW-ACC_BITS:0]     sum_hi;
    logic                       beat_ovf;
    logic                       ovf_d;
    logic signed [ACC_BITS-1:0] acc_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aixh_mxc_pex_lane u_lane (
            .mode_i (in_mode),
            .u_i    (in_udata[8*i +: 8]),
            .v_i    (in_vdata[8*i +: 8]),
            .prod_o (lane_prod[i])
        );
    end

    always_comb begin
        beat_prod = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_prod = beat_prod + ProdW'(lane_prod[i]);
        end
        case (in_shift)
            ShiftX1:   beat_wp = WpW'(beat_prod);
            ShiftX2p8: beat_wp = WpW'(beat_prod) <<< 8;
            default:   beat_wp = WpW'(beat_prod) <<< 16;
        endcase
    end

    // A held result that nobody takes freezes the whole cell.
    assign advance  = ~(out_valid_q & ~out_ready);
    assign in_ready = aixh_core_rst | advance;

    always_comb begin
        acc_base = '0;
        if (!st_afresh_q[MSTAGES-1]) begin
            acc_base = SumW'(acc_q);
        end
        acc_sum  = acc_base + SumW'(st_wp_q[MSTAGES-1]);
        // Full-precision sum fits iff all bits from the ACC_BITS sign bit upward agree.
        sum_hi   = acc_sum[SumW-1:ACC_BITS-1];
        beat_ovf = ~((&sum_hi) | ~(|sum_hi));
        ovf_d    = beat_ovf | (~st_afresh_q[MSTAGES-1] & ovf_q);
        if (beat_ovf && SAT) begin
            acc_d = acc_sum[SumW-1] ? {1'b1, {(ACC_BITS-1){1'b0}}}
                                    : {1'b0, {(ACC_BITS-1){1'b1}}};
        end else begin
            acc_d = acc_sum[ACC_BITS-1:0];
        end
    end

    always_ff @(posedge aixh_core_clk2x) begin
        if (aixh_core_rst) begin
            st_valid_q  <= '0;
            st_afresh_q <= '0;
            st_last_q   <= '0;
            for (int i = 0; i < MSTAGES; i++) begin
                st_wp_q[i] <= '0;
            end
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else if (advance) begin
            for (int i = MSTAGES - 1; i > 0; i--) begin
                st_valid_q[i]  <= st_valid_q[i-1];
                st_afresh_q[i] <= st_afresh_q[i-1];
                st_last_q[i]   <= st_last_q[i-1];
                st_wp_q[i]     <= st_wp_q[i-1];
            end
            st_valid_q[0]  <= in_valid;
            st_afresh_q[0] <= in_afresh;
            st_last_q[0]   <= in_last;
            st_wp_q[0]     <= beat_wp;

            // Any held result has been taken by now unless a new one replaces it.
            out_valid_q <= 1'b0;
            if (st_valid_q[MSTAGES-1]) begin
                if (st_last_q[MSTAGES-1]) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= acc_d;
                    out_ovf_q   <= ovf_d;
                    acc_q       <= '0;
                    ovf_q       <= 1'b0;
                end else begin
                    acc_q <= acc_d;
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_aixh_mxc_upper_ptile_cell_pex.sv
// Self-checking bench: table vectors and random accumulations through a scoreboard,
// plus hand sequences for latency, backpressure, saturation/wrap and reset.
module tb_aixh_mxc_upper_ptile_cell_pex;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_afresh;
    logic        in_last;
    logic        out_ready;
    logic [1:0]  in_mode;
    logic [1:0]  in_shift;
    logic [15:0] in_udata;
    logic [15:0] in_vdata;

    logic        in_ready;
    logic        out_valid;
    logic        out_ovf;
    logic [47:0] out_data;

    logic        sat_in_ready, sat_out_valid, sat_out_ovf;
    logic [19:0] sat_out_data;
    logic        wrap_in_ready, wrap_out_valid, wrap_out_ovf;
    logic [19:0] wrap_out_data;

    aixh_mxc_upper_ptile_cell_pex #(
        .LANES(2), .MSTAGES(2), .ACC_BITS(48), .SAT(1'b0)
    ) dut (
        .aixh_core_clk2x (clk),
        .aixh_core_rst   (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_mode         (in_mode),
        .in_shift        (in_shift),
        .in_afresh       (in_afresh),
        .in_last         (in_last),
        .in_udata        (in_udata),
        .in_vdata        (in_vdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_ovf         (out_ovf)
    );

    aixh_mxc_upper_ptile_cell_pex #(
        .LANES(2), .MSTAGES(2), .ACC_BITS(20), .SAT(1'b1)
    ) dut_sat (
        .aixh_core_clk2x (clk),
        .aixh_core_rst   (rst),
        .in_valid        (in_valid),
        .in_ready        (sat_in_ready),
        .in_mode         (in_mode),
        .in_shift        (in_shift),
        .in_afresh       (in_afresh),
        .in_last         (in_last),
        .in_udata        (in_udata),
        .in_vdata        (in_vdata),
        .out_valid       (sat_out_valid),
        .out_ready       (out_ready),
        .out_data        (sat_out_data),
        .out_ovf         (sat_out_ovf)
    );

    aixh_mxc_upper_ptile_cell_pex #(
        .LANES(2), .MSTAGES(2), .ACC_BITS(20), .SAT(1'b0)
    ) dut_wrap (
        .aixh_core_clk2x (clk),
        .aixh_core_rst   (rst),
        .in_valid        (in_valid),
        .in_ready        (wrap_in_ready),
        .in_mode         (in_mode),
        .in_shift        (in_shift),
        .in_afresh       (in_afresh),
        .in_last         (in_last),
        .in_udata        (in_udata),
        .in_vdata        (in_vdata),
        .out_valid       (wrap_out_valid),
        .out_ready       (out_ready),
        .out_data        (wrap_out_data),
        .out_ovf         (wrap_out_ovf)
    );

    typedef struct packed {
        logic [47:0] data;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  shift;
        logic [15:0] u;
        logic [15:0] v;
        longint      exp;
    } vec_t;

    exp_t   sb [$];
    exp_t   mon_e;
    vec_t   vecs [10];
    int     total = 0;
    int     bad   = 0;
    longint macc  = 0;
    bit     rnd_bp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic longint sx4(input logic [3:0] n);
        return longint'($signed(n));
    endfunction

    function automatic longint model_beat(input logic [1:0] mode, input logic [1:0] shift,
                                          input logic [15:0] u, input logic [15:0] v);
        longint     s;
        logic [7:0] a;
        logic [7:0] b;
        s = 0;
        for (int l = 0; l < 2; l++) begin
            a = u[8*l +: 8];
            b = v[8*l +: 8];
            if (mode == 2'b00) begin
                s += sx4(a[3:0]) * sx4(b[3:0]) + sx4(a[7:4]) * sx4(b[7:4]);
            end else if (mode == 2'b10) begin
                s += longint'({56'b0, a}) * longint'($signed(b));
            end else begin
                s += longint'($signed(a)) * longint'($signed(b));
            end
        end
        if (shift == 2'b00) return s;
        if (shift == 2'b01) return s * 256;
        return s * 65536;
    endfunction

    // Present one beat and hold it until accepted; returns at posedge + 1.
    task automatic drive_beat(input logic [1:0] mode, input logic [1:0] shift,
                              input logic [15:0] u, input logic [15:0] v,
                              input logic afresh, input logic last, output bit ok);
        int waited;
        waited    = 0;
        in_valid  = 1'b1;
        in_mode   = mode;
        in_shift  = shift;
        in_udata  = u;
        in_vdata  = v;
        in_afresh = afresh;
        in_last   = last;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        ok = in_ready;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=0 required 1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [1:0] mode, input logic [1:0] shift,
                        input logic [15:0] u, input logic [15:0] v,
                        input logic afresh, input logic last);
        bit ok;
        drive_beat(mode, shift, u, v, afresh, last, ok);
        if (ok) begin
            if (afresh) macc = 0;
            macc += model_beat(mode, shift, u, v);
            if (last) begin
                sb.push_back('{data: macc[47:0], ovf: 1'b0});
                macc = 0;
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d required 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_sat_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!sat_out_valid && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("sat_seen", sat_out_valid, 1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got 0x%0h expected none", out_data);
            end else begin
                mon_e = sb.pop_front();
                check("sb_data", out_data, mon_e.data);
                check("sb_ovf", out_ovf, mon_e.ovf);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_bp) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        longint t;

        vecs[0] = '{2'b01, 2'b00, {8'd3, 8'hFE}, {8'd5, 8'd7}, 1};
        vecs[1] = '{2'b00, 2'b00, 16'h0021, 16'h003F, 5};
        vecs[2] = '{2'b10, 2'b01, 16'h00FF, 16'h0002, 130560};
        vecs[3] = '{2'b11, 2'b00, 16'h8080, 16'h8080, 32768};
        vecs[4] = '{2'b10, 2'b00, 16'hFFFF, 16'h8080, -65280};
        vecs[5] = '{2'b00, 2'b00, 16'h8888, 16'h8888, 256};
        vecs[6] = '{2'b01, 2'b10, 16'h007F, 16'h0081, -1057030144};
        vecs[7] = '{2'b01, 2'b11, 16'h0001, 16'h0001, 65536};
        vecs[8] = '{2'b00, 2'b00, 16'h7F00, 16'h1800, 15};
        vecs[9] = '{2'b10, 2'b10, 16'h80FF, 16'h7F01, 1082064896};

        rst = 1'b1; in_valid = 1'b0; in_afresh = 1'b0; in_last = 1'b0;
        in_mode = 2'b00; in_shift = 2'b00; in_udata = '0; in_vdata = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Single-beat afresh+last vectors with hand-derived results.
        foreach (vecs[i]) begin
            drive_beat(vecs[i].mode, vecs[i].shift, vecs[i].u, vecs[i].v, 1'b1, 1'b1, ok);
            if (ok) begin
                t = vecs[i].exp;
                sb.push_back('{data: t[47:0], ovf: 1'b0});
            end
        end
        wait_drain();

        // Latency: result appears MSTAGES+1 cycles after acceptance.
        send(2'b01, 2'b00, {8'd3, 8'hFE}, {8'd5, 8'd7}, 1'b1, 1'b1);
        @(negedge clk);
        check("lat_c1", out_valid, 0);
        @(negedge clk);
        check("lat_c2", out_valid, 0);
        @(negedge clk);
        check("lat_c3", out_valid, 1);
        wait_drain();

        // A non-afresh beat after a completed result starts from zero.
        send(2'b01, 2'b00, 16'h0009, 16'h0009, 1'b1, 1'b1);
        send(2'b01, 2'b00, 16'h0004, 16'h0002, 1'b0, 1'b1);
        wait_drain();

        // Backpressure: first result held while the second accumulation is in flight.
        out_ready = 1'b0;
        send(2'b01, 2'b00, {8'd3, 8'hFE}, {8'd5, 8'd7}, 1'b1, 1'b1);
        send(2'b01, 2'b00, 16'h000A, 16'h000A, 1'b1, 1'b0);
        send(2'b01, 2'b01, 16'h0001, 16'h0001, 1'b0, 1'b1);
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_hold_data", out_data, 48'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Random multi-beat accumulations under random backpressure.
        rnd_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 16'($urandom), 16'($urandom),
                 ($urandom_range(0, 3) == 0), (i == 39) || ($urandom_range(0, 3) == 0));
        end
        rnd_bp = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Saturating versus wrapping 20-bit accumulators.
        send(2'b01, 2'b10, 16'h7F7F, 16'h7F7F, 1'b1, 1'b0);
        send(2'b01, 2'b10, 16'h7F7F, 16'h7F7F, 1'b0, 1'b1);
        wait_sat_valid();
        check("sat_pos_data", sat_out_data, 20'h7FFFF);
        check("sat_pos_ovf", sat_out_ovf, 1);
        check("wrap_pos_data", wrap_out_data, 20'h40000);
        check("wrap_pos_ovf", wrap_out_ovf, 1);
        wait_drain();

        send(2'b01, 2'b10, 16'h7F7F, 16'h8080, 1'b1, 1'b1);
        wait_sat_valid();
        check("sat_neg_data", sat_out_data, 20'h80000);
        check("sat_neg_ovf", sat_out_ovf, 1);
        check("wrap_neg_data", wrap_out_data, 20'h00000);
        check("wrap_neg_ovf", wrap_out_ovf, 1);
        wait_drain();

        send(2'b01, 2'b00, 16'h0002, 16'h0003, 1'b1, 1'b1);
        wait_sat_valid();
        check("sat_clr_data", sat_out_data, 20'd6);
        check("sat_clr_ovf", sat_out_ovf, 0);
        check("wrap_clr_data", wrap_out_data, 20'd6);
        check("wrap_clr_ovf", wrap_out_ovf, 0);
        wait_drain();

        // Reset with a result held and a beat stuck mid-pipeline.
        out_ready = 1'b0;
        send(2'b01, 2'b00, 16'h0003, 16'h0004, 1'b1, 1'b1);
        send(2'b01, 2'b00, 16'h0005, 16'h0005, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_pre_out_valid", out_valid, 1);
        check("rst_pre_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        sb.delete();
        macc = 0;
        @(negedge clk);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_out_data", out_data, 0);
        check("rst_mid_out_ovf", out_ovf, 0);
        check("rst_mid_in_ready2", in_ready, 1);
        @(posedge clk);
        #1;
        send(2'b01, 2'b00, 16'h0002, 16'h0007, 1'b0, 1'b1);
        send(2'b01, 2'b00, 16'h0006, 16'h0006, 1'b1, 1'b1);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
